dg_tri_bus_keeper: RTL and testbench



---
 rtl/dg_tri_pkg.sv | 40 ++++
 rtl/dg_tri_resolve.sv | 36 +++
 rtl/dg_tri_bus_keeper.sv | 205 ++++++++++++++++++++
 tb/tb_dg_tri_bus_keeper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dg_tri_pkg.sv
// -----------------------------------------------------------------------------
// dg_tri_pkg
// Shared types for the tri-state bus keeper:
//   - keeper FSM state encoding (DRIVEN, HELD, DECAYED, CONTENTION)
//   - per-cycle driver classification codes (FLOAT, DRIVE, CONFLICT)
//   - a helper that turns the reduced driver summary into a class code
// No ports; imported by dg_tri_resolve and dg_tri_bus_keeper.
// -----------------------------------------------------------------------------
package dg_tri_pkg;

  // Encodings are visible on the 'state' output, so they are fixed here.
  typedef enum logic [1:0] {
    DRIVEN     = 2'd0,
    HELD       = 2'd1,
    DECAYED    = 2'd2,
    CONTENTION = 2'd3
  } keeper_state_e;

  typedef enum logic [1:0] {
    FLOAT    = 2'd0,
    DRIVE    = 2'd1,
    CONFLICT = 2'd2
  } drv_class_e;

  // any_one / any_zero: some enabled driver pushes a 1 / a 0 onto the net.
  function automatic drv_class_e classify(input logic any_en,
                                          input logic any_one,
                                          input logic any_zero);
    drv_class_e cls;
    if (!any_en) begin
      cls = FLOAT;
    end else if (any_one && any_zero) begin
      cls = CONFLICT;
    end else begin
      cls = DRIVE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/dg_tri_resolve.sv
// -----------------------------------------------------------------------------
// dg_tri_resolve
// Purely combinational resolution of N_DRV decomposed tri-state drivers onto
// one net.
// Ports:
//   drv_en    in  N_DRV  per-driver output enable (1 = driving)
//   drv_val   in  N_DRV  per-driver value, ignored where drv_en is 0
//   drv_class out 2      FLOAT / DRIVE / CONFLICT for this cycle
//   res_val   out 1      agreed value of the enabled drivers (valid on DRIVE)
// -----------------------------------------------------------------------------
module dg_tri_resolve
  import dg_tri_pkg::*;
#(
  parameter int N_DRV = 3
) (
  input  logic [N_DRV-1:0] drv_en,
  input  logic [N_DRV-1:0] drv_val,
  output drv_class_e       drv_class,
  output logic             res_val
);

  logic any_en;
  logic any_one;
  logic any_zero;

  // Masking with drv_en makes disabled drivers invisible, whatever their value.
  // With a single driver any_one and any_zero are mutually exclusive, so
  // CONFLICT can never be produced.
  assign any_en   = |drv_en;
  assign any_one  = |(drv_en & drv_val);
  assign any_zero = |(drv_en & ~drv_val);

  assign drv_class = classify(any_en, any_one, any_zero);
  assign res_val   = any_one;

endmodule

// File: rtl/dg_tri_bus_keeper.sv
// -----------------------------------------------------------------------------
// dg_tri_bus_keeper
// Bus-hold keeper for one shared net fed by N_DRV tri-state cells. Produces a
// clean registered level, holds the last driven value while the net floats,
// declares it decayed after FLOAT_LIMIT floating cycles, and tracks driver
// contention and output toggles.
// Ports:
//   clk            in  1      rising-edge clock
//   rst            in  1      synchronous active-high reset
//   drv_en         in  N_DRV  per-driver output enable
//   drv_val        in  N_DRV  per-driver value
//   clr_err        in  1      clears contention flag and contention_cnt
//   y              out 1      resolved / kept net value
//   y_valid        out 1      y is driven or still within its hold window
//   state          out 2      keeper FSM state
//   float_timeout  out 1      one-cycle pulse on HELD -> DECAYED
//   contention     out 1      sticky contention flag
//   contention_cnt out CNT_W  saturating contention-cycle count
//   toggle_cnt     out CNT_W  wrapping count of y value changes
// All outputs are registered: one cycle from inputs to outputs.
// -----------------------------------------------------------------------------
module dg_tri_bus_keeper
  import dg_tri_pkg::*;
#(
  parameter int   N_DRV       = 3,
  parameter int   FLOAT_LIMIT = 8,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DRV-1:0] drv_en,
  input  logic [N_DRV-1:0] drv_val,
  input  logic             clr_err,
  output logic             y,
  output logic             y_valid,
  output logic [1:0]       state,
  output logic             float_timeout,
  output logic             contention,
  output logic [CNT_W-1:0] contention_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  // The float counter only needs to reach FLOAT_LIMIT.
  localparam int              FC_W     = $clog2(FLOAT_LIMIT + 1);
  localparam logic [FC_W-1:0] FC_LIMIT = FC_W'(FLOAT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Input classification
  // ---------------------------------------------------------------------------
  drv_class_e drv_class;
  logic       res_val;

  dg_tri_resolve #(
    .N_DRV (N_DRV)
  ) u_resolve (
    .drv_en    (drv_en),
    .drv_val   (drv_val),
    .drv_class (drv_class),
    .res_val   (res_val)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  keeper_state_e    state_q,          state_d;
  logic             y_q,              y_d;
  logic             y_valid_q,        y_valid_d;
  logic [FC_W-1:0]  float_cnt_q,      float_cnt_d;
  logic             float_timeout_q,  float_timeout_d;
  logic             contention_q,     contention_d;
  logic [CNT_W-1:0] contention_cnt_q, contention_cnt_d;
  logic [CNT_W-1:0] toggle_cnt_q,     toggle_cnt_d;

  // ---------------------------------------------------------------------------
  // Keeper FSM: next state, kept value, validity and float counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d         = state_q;
    y_d             = y_q;
    y_valid_d       = y_valid_q;
    float_cnt_d     = float_cnt_q;
    float_timeout_d = 1'b0;

    case (drv_class)
      DRIVE: begin
        state_d     = DRIVEN;
        y_d         = res_val;
        y_valid_d   = 1'b1;
        float_cnt_d = '0;
      end

      CONFLICT: begin
        // The net level is undefined; y keeps its old value but is not valid.
        state_d     = CONTENTION;
        y_valid_d   = 1'b0;
        float_cnt_d = '0;
      end

      default: begin // FLOAT
        case (state_q)
          DRIVEN: begin
            // First floating cycle counts as 1.
            state_d     = HELD;
            float_cnt_d = FC_W'(1);
          end

          HELD: begin
            // Counter already covers FLOAT_LIMIT floating cycles, so this one
            // (FLOAT_LIMIT+1) is where the held charge is considered gone.
            if (float_cnt_q == FC_LIMIT) begin
              state_d         = DECAYED;
              y_valid_d       = 1'b0;
              float_cnt_d     = '0;
              float_timeout_d = 1'b1;
            end else begin
              float_cnt_d = float_cnt_q + FC_W'(1);
            end
          end

          CONTENTION: begin
            // Nothing meaningful was being held, so no timeout pulse.
            state_d     = DECAYED;
            y_valid_d   = 1'b0;
            float_cnt_d = '0;
          end

          default: begin // DECAYED: stay, y keeps its stale value
            state_d     = DECAYED;
            y_valid_d   = 1'b0;
          end
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics: contention flag/count and toggle count
  // ---------------------------------------------------------------------------
  always_comb begin
    contention_d     = contention_q;
    contention_cnt_d = contention_cnt_q;
    toggle_cnt_d     = toggle_cnt_q;

    // A conflict in the same cycle as the clear is counted after the clear.
    if (clr_err) begin
      contention_d     = 1'b0;
      contention_cnt_d = '0;
    end

    if (drv_class == CONFLICT) begin
      contention_d = 1'b1;
      if (contention_cnt_d != CNT_MAX) begin
        contention_cnt_d = contention_cnt_d + CNT_W'(1);
      end
    end

    // Wraps naturally at 2^CNT_W.
    if (y_d != y_q) begin
      toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q          <= DECAYED;
      y_q              <= RESET_VAL;
      y_valid_q        <= 1'b0;
      float_cnt_q      <= '0;
      float_timeout_q  <= 1'b0;
      contention_q     <= 1'b0;
      contention_cnt_q <= '0;
      toggle_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      y_q              <= y_d;
      y_valid_q        <= y_valid_d;
      float_cnt_q      <= float_cnt_d;
      float_timeout_q  <= float_timeout_d;
      contention_q     <= contention_d;
      contention_cnt_q <= contention_cnt_d;
      toggle_cnt_q     <= toggle_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign y              = y_q;
  assign y_valid        = y_valid_q;
  assign state          = state_q;
  assign float_timeout  = float_timeout_q;
  assign contention     = contention_q;
  assign contention_cnt = contention_cnt_q;
  assign toggle_cnt     = toggle_cnt_q;

endmodule

// File: tb/tb_dg_tri_bus_keeper.sv
// -----------------------------------------------------------------------------
// tb_dg_tri_bus_keeper
// Scoreboard bench for dg_tri_bus_keeper (N_DRV=3, FLOAT_LIMIT=8, CNT_W=8).
// Each driven cycle steps a behavioural reference model and queues the
// expected outputs; one clock later the DUT outputs are popped and compared.
// Directed checks against fixed values cover the listed scenarios.
// -----------------------------------------------------------------------------
module tb_dg_tri_bus_keeper;

  localparam int   N_DRV       = 3;
  localparam int   FLOAT_LIMIT = 8;
  localparam int   CNT_W       = 8;
  localparam logic RESET_VAL   = 1'b0;

  logic             clk;
  logic             rst;
  logic [N_DRV-1:0] drv_en;
  logic [N_DRV-1:0] drv_val;
  logic             clr_err;
  logic             y;
  logic             y_valid;
  logic [1:0]       state;
  logic             float_timeout;
  logic             contention;
  logic [CNT_W-1:0] contention_cnt;
  logic [CNT_W-1:0] toggle_cnt;

  dg_tri_bus_keeper #(
    .N_DRV       (N_DRV),
    .FLOAT_LIMIT (FLOAT_LIMIT),
    .CNT_W       (CNT_W),
    .RESET_VAL   (RESET_VAL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .drv_en         (drv_en),
    .drv_val        (drv_val),
    .clr_err        (clr_err),
    .y              (y),
    .y_valid        (y_valid),
    .state          (state),
    .float_timeout  (float_timeout),
    .contention     (contention),
    .contention_cnt (contention_cnt),
    .toggle_cnt     (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             y;
    logic             y_valid;
    logic [1:0]       state;
    logic             float_timeout;
    logic             contention;
    logic [CNT_W-1:0] contention_cnt;
    logic [CNT_W-1:0] toggle_cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t m;          // reference model outputs
  int   m_fcnt;     // reference model float counter
  int   n_cmp;
  int   n_err;
  int   pulses;     // observed float_timeout pulses in a window
  int   invalid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model written directly from the keeper's transition rules.
  task automatic model_step(input logic [N_DRV-1:0] en, input logic [N_DRV-1:0] val,
                            input logic clr, input logic r);
    int   n_one;
    int   n_zero;
    logic prev_y;
    logic conflict;
    if (r) begin
      m.y = RESET_VAL; m.y_valid = 1'b0; m.state = 2'd2; m.float_timeout = 1'b0;
      m.contention = 1'b0; m.contention_cnt = '0; m.toggle_cnt = '0;
      m_fcnt = 0;
      return;
    end
    n_one = 0; n_zero = 0;
    for (int i = 0; i < N_DRV; i++) begin
      if (en[i] &&  val[i]) n_one++;
      if (en[i] && !val[i]) n_zero++;
    end
    conflict = (n_one > 0) && (n_zero > 0);
    prev_y = m.y;
    m.float_timeout = 1'b0;
    if (n_one + n_zero == 0) begin
      case (m.state)
        2'd0: begin m.state = 2'd1; m_fcnt = 1; end
        2'd1: begin
          if (m_fcnt == FLOAT_LIMIT) begin
            m.state = 2'd2; m.y_valid = 1'b0; m.float_timeout = 1'b1;
          end else begin
            m_fcnt++;
          end
        end
        2'd3: begin m.state = 2'd2; m.y_valid = 1'b0; end
        default: ;
      endcase
    end else if (conflict) begin
      m.state = 2'd3; m.y_valid = 1'b0; m_fcnt = 0;
    end else begin
      m.state = 2'd0; m.y = (n_one > 0); m.y_valid = 1'b1; m_fcnt = 0;
    end
    if (clr) begin
      m.contention     = conflict;
      m.contention_cnt = conflict ? 8'd1 : 8'd0;
    end else if (conflict) begin
      m.contention = 1'b1;
      if (m.contention_cnt != 8'hFF) m.contention_cnt = m.contention_cnt + 8'd1;
    end
    if (m.y != prev_y) m.toggle_cnt = m.toggle_cnt + 8'd1;
  endtask

  // Drive one cycle, queue the expectation, then compare after the edge.
  task automatic cycle(input logic [N_DRV-1:0] en, input logic [N_DRV-1:0] val,
                       input logic clr, input logic r);
    obs_t e;
    drv_en = en; drv_val = val; clr_err = clr; rst = r;
    model_step(en, val, clr, r);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("y",              32'(y),              32'(e.y));
      check("y_valid",        32'(y_valid),        32'(e.y_valid));
      check("state",          32'(state),          32'(e.state));
      check("float_timeout",  32'(float_timeout),  32'(e.float_timeout));
      check("contention",     32'(contention),     32'(e.contention));
      check("contention_cnt", 32'(contention_cnt), 32'(e.contention_cnt));
      check("toggle_cnt",     32'(toggle_cnt),     32'(e.toggle_cnt));
    end
    if (float_timeout) pulses++;
    if (!y_valid) invalid_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; pulses = 0; invalid_seen = 0; m_fcnt = 0;
    m = '0;
    rst = 1'b1; drv_en = '0; drv_val = '0; clr_err = 1'b0;

    // Reset, then one floating cycle.
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    cycle(3'b000, 3'b000, 1'b0, 1'b0);
    check("rst_y",       32'(y),              32'd0);
    check("rst_valid",   32'(y_valid),        32'd0);
    check("rst_state",   32'(state),          32'd2);
    check("rst_ccnt",    32'(contention_cnt), 32'd0);
    check("rst_tcnt",    32'(toggle_cnt),     32'd0);

    // Drive 1 once, then float 10 cycles: valid through 8, gone after 9.
    cycle(3'b001, 3'b001, 1'b0, 1'b0);
    check("drv_y", 32'(y), 32'd1);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(3'b000, 3'b000, 1'b0, 1'b0);
      check($sformatf("decay_valid_f%0d", k), 32'(y_valid), (k <= FLOAT_LIMIT) ? 32'd1 : 32'd0);
      check($sformatf("decay_y_f%0d", k), 32'(y), 32'd1);
    end
    check("decay_pulses", 32'(pulses), 32'd1);
    check("decay_tcnt",   32'(toggle_cnt), 32'd1);

    // Three conflict cycles, then a clean drive from driver 2.
    for (int k = 0; k < 3; k++) cycle(3'b011, 3'b010, 1'b0, 1'b0);
    check("conf_state", 32'(state),          32'd3);
    check("conf_flag",  32'(contention),     32'd1);
    check("conf_cnt",   32'(contention_cnt), 32'd3);
    check("conf_y",     32'(y),              32'd1);
    cycle(3'b100, 3'b100, 1'b0, 1'b0);
    check("redrv_state", 32'(state), 32'd0);
    check("redrv_y",     32'(y),     32'd1);

    // Saturation, then clear coinciding with conflict, then plain clear.
    for (int k = 0; k < 300; k++) cycle(3'b101, 3'b001, 1'b0, 1'b0);
    check("sat_cnt", 32'(contention_cnt), 32'd255);
    cycle(3'b101, 3'b001, 1'b1, 1'b0);
    check("clr_conf_cnt",  32'(contention_cnt), 32'd1);
    check("clr_conf_flag", 32'(contention),     32'd1);
    pulses = 0;
    cycle(3'b000, 3'b000, 1'b1, 1'b0);
    check("clr_cnt",      32'(contention_cnt), 32'd0);
    check("clr_flag",     32'(contention),     32'd0);
    check("conf_to_dec",  32'(state),          32'd2);
    cycle(3'b000, 3'b000, 1'b0, 1'b0);
    check("conf_dec_pulses", 32'(pulses), 32'd0);

    // Toggle driver 0 every cycle; y starts at 1, so every cycle changes y.
    invalid_seen = 0;
    for (int i = 0; i < 260; i++) cycle(3'b001, 3'(i % 2), 1'b0, 1'b0);
    check("tog_valid_drops", 32'(invalid_seen), 32'd0);
    check("tog_cnt", 32'(toggle_cnt), 32'd5); // 1 earlier + 260, mod 256

    // Reset in the middle of HELD (float counter at 5).
    cycle(3'b001, 3'b001, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 5; k++) cycle(3'b000, 3'b000, 1'b0, 1'b0);
    check("held_state", 32'(state), 32'd1);
    cycle(3'b000, 3'b000, 1'b0, 1'b1);
    check("midrst_state", 32'(state),   32'd2);
    check("midrst_y",     32'(y),       32'(RESET_VAL));
    check("midrst_valid", 32'(y_valid), 32'd0);
    for (int k = 0; k < 12; k++) cycle(3'b000, 3'b000, 1'b0, 1'b0);
    check("midrst_pulses", 32'(pulses), 32'd0);

    // Random traffic against the model, floats weighted up to reach decay.
    for (int k = 0; k < 400; k++) begin
      logic [N_DRV-1:0] en;
      en = ($urandom_range(0, 3) == 0) ? 3'(0) : 3'($urandom);
      if ($urandom_range(0, 1) == 0) en = '0;
      cycle(en, 3'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
